scoreboard_hazard_unit: RTL and testbench
=========================================

# scoreboard_hazard_unit

Parametrised successor to the G1 hazard-detection and forwarding pair: one per-register scoreboard replaces the fixed EXE/MEM destination compares. Each in-flight writer is tracked with its own result latency, so loads and multi-cycle ops are handled. The unit sits beside the ID stage. Combinationally it decides stall or issue for the instruction in ID, and it registers per-operand bypass selects that the EXECUTE stage uses one cycle later.

## Interface
Parameters:
- NREGS, 16, architectural register count; ADDR_W = $clog2(NREGS)
- DEPTH, 3, bypass points after ID (1=EX … DEPTH=WB); POS_W = $clog2(DEPTH+1)
- ZERO_REG, 1, 1: register 0 hardwired zero, never tracked or stalled on

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  clock
  - rst  in  1  asynchronous active-high reset
- Control inputs:
  - forward_EN  in  1  0: any pending source stalls until retired
  - freeze  in  1  global pipeline hold (memory busy); all state held
  - flush  in  1  kill instruction in ID (branch taken); no issue
- ID-stage instruction:
  - id_valid  in  1  ID holds a real instruction
  - id_src1, id_src2  in  ADDR_W  source registers
  - id_src1_used, id_src2_used  in  1  source is actually read
  - id_dest  in  ADDR_W  destination; id_wb_en  in  1  writes back
  - id_lat  in  POS_W  cycles after issue until result exists (ALU 1, load 2)
- Outputs:
  - hazard_detected  out  1  combinational stall request to IF/ID
  - issue  out  1  combinational: id_valid & ~hazard_detected & ~freeze & ~flush
  - ex_src1_sel, ex_src2_sel  out  POS_W  registered bypass select for EX; 0 = register file, k = bypass point k
  - sb_empty  out  1  no entry valid

## Operation
- Entry per register r: valid, pos[POS_W], lat[POS_W].
  - On issue with id_wb_en (and id_dest≠0 when ZERO_REG): entry ← valid=1, pos=1, lat=clamp(id_lat).
  - Clamp: id_lat 0 → 1; id_lat ≥ DEPTH → DEPTH-1.
- Each non-freeze cycle every valid entry advances pos by 1. The entry at pos=DEPTH clears at that edge (register file written that cycle).
- Register file is write-before-read. A source whose entry has pos=DEPTH is therefore not pending.
- Per used source s (s≠0 when ZERO_REG), with e = entry[s] and pending = e.valid & e.pos<DEPTH:
  - forward_EN=1: stall if pending & e.pos < e.lat; else sel = pending ? e.pos+1 : 0
  - forward_EN=0: stall if pending; sel = 0
- hazard_detected = id_valid & ~flush & (stall1 | stall2). It is independent of freeze.
- WAW: issue overwrites the existing entry. The newer writer always retires later (in-order pipeline).
- Same-cycle issue plus retire or advance on id_dest: the new entry wins.
- Hazard checks read the entry state before this cycle's update. A consumer whose src equals its own dest sees the old producer.

## Timing
- Reset (async): all entries invalid; ex_src*_sel=0; sb_empty=1. hazard_detected and issue then follow inputs combinationally (0 while id_valid=0).
- ex_src*_sel update at the edge:
  - issue=1: load the computed sel.
  - ~issue & ~freeze: load 0 (bubble).
  - freeze: hold.
- Stall inserts a bubble: entries still advance, so a stalled consumer resolves without extra logic.
- Latency, DEPTH=3:
  - ALU→use back-to-back: 0 stall, sel=2.
  - Load→use: 1 stall, then sel=3.
  - Distance ≥3: sel=0.
- flush and a hazard in the same cycle: hazard_detected=0, issue=0.
- rst asserted mid-stream: all in-flight tracking is discarded immediately.

## Structure
- Package g1_pipe_pkg holds:
  - SEL_REGFILE=0
  - default DEPTH, NREGS
  - clamp_lat function
  - typedef sb_entry_t {valid, pos, lat}
- Sub-module sb_entry: a single register's entry with advance, retire and overwrite logic.
  - Instantiated NREGS times by generate; entry 0 tied off when ZERO_REG=1.
- Top level holds the two source-lookup muxes, the stall/select logic and the output registers.

## Test plan
- ALU r1←, next instr reads r1, forward_EN=1 → hazard_detected=0, ex_src1_sel=2 next cycle.
- Load r2 (lat 2) then use r2 → one cycle hazard_detected=1, then issue with ex_src2_sel=3; third-cycle use gives sel 0.
- Same as ALU case with forward_EN=0 → hazard_detected=1 for 2 cycles, then issue with sel=0.
- Producer issued, then freeze for 4 cycles mid-flight → pos held; after release, stall/sel sequence identical to the unfrozen run.
- Two writers to r3 (load, then ALU) followed by a reader of r3 → select follows the younger ALU entry (sel=2); the older entry is ignored. Reader of r0 with ZERO_REG=1 → never stalls, sel 0.
- Hazard present and flush=1 → hazard_detected=0, issue=0, ex_src*_sel=0. rst mid-flight → sb_empty=1 asynchronously.

Source files
------------

// File: rtl/g1_pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | g1_pipe_pkg : shared types, defaults and helpers for the scoreboard |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package g1_pipe_pkg;

   localparam int DEFAULT_NREGS = 16;
   localparam int DEFAULT_DEPTH = 3;
   // Entry fields are sized for DEPTH up to 15 so the struct is parameter-independent
   localparam int MAX_POS_W     = 4;

   localparam logic [MAX_POS_W-1:0] SEL_REGFILE = '0;

   typedef struct packed {
      logic                 valid;
      logic [MAX_POS_W-1:0] pos;
      logic [MAX_POS_W-1:0] lat;
   } sb_entry_t;

   function automatic logic [MAX_POS_W-1:0] clamp_lat(input logic [MAX_POS_W-1:0] lat,
                                                      input int depth);
      logic [MAX_POS_W-1:0] lim;
      lim = MAX_POS_W'(depth - 1);
      if (lat == '0) begin
         return MAX_POS_W'(1);
      end
      if (lat > lim) begin
         return lim;
      end
      return lat;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sb_entry : one register's in-flight writer (advance/retire/overwrite)|
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module sb_entry
   import g1_pipe_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 wr_en,
   input  logic [MAX_POS_W-1:0] wr_lat,
   output sb_entry_t            entry
);

   sb_entry_t entry_d;
   sb_entry_t entry_q;

   always_comb begin
      entry_d = entry_q;
      if (!freeze) begin
         if (entry_q.valid) begin
            if (entry_q.pos == MAX_POS_W'(DEPTH)) begin
               entry_d = '0;
            end else begin
               entry_d.pos = entry_q.pos + MAX_POS_W'(1);
            end
         end
         // A new writer replaces whatever is in flight, including a retiring one
         if (wr_en) begin
            entry_d.valid = 1'b1;
            entry_d.pos   = MAX_POS_W'(1);
            entry_d.lat   = wr_lat;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry = entry_q;

endmodule
`default_nettype wire

// File: rtl/scoreboard_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scoreboard_hazard_unit : per-register scoreboard, stall and bypass  |
// | Revision               : 1.0                                       |
// +--------------------------------------------------------------------+
module scoreboard_hazard_unit
   import g1_pipe_pkg::*;
#(
   parameter int NREGS    = DEFAULT_NREGS,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter bit ZERO_REG = 1'b1,
   localparam int ADDR_W  = $clog2(NREGS),
   localparam int POS_W   = $clog2(DEPTH + 1)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              forward_EN,
   input  logic              freeze,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [ADDR_W-1:0] id_src1,
   input  logic [ADDR_W-1:0] id_src2,
   input  logic              id_src1_used,
   input  logic              id_src2_used,
   input  logic [ADDR_W-1:0] id_dest,
   input  logic              id_wb_en,
   input  logic [POS_W-1:0]  id_lat,
   output logic              hazard_detected,
   output logic              issue,
   output logic [POS_W-1:0]  ex_src1_sel,
   output logic [POS_W-1:0]  ex_src2_sel,
   output logic              sb_empty
);

   sb_entry_t            entries [NREGS];
   logic [MAX_POS_W-1:0] wr_lat;
   logic                 stall1, stall2;
   logic [MAX_POS_W-1:0] sel1, sel2;
   logic [POS_W-1:0]     sel1_d, sel1_q, sel2_d, sel2_q;
   logic                 any_valid;

   assign wr_lat = clamp_lat(MAX_POS_W'(id_lat), DEPTH);

   for (genvar r = 0; r < NREGS; r++) begin : g_entry
      if (ZERO_REG && (r == 0)) begin : g_zero
         assign entries[r] = '0;
      end else begin : g_track
         sb_entry #(.DEPTH(DEPTH)) u_entry (
            .clk    (clk),
            .rst    (rst),
            .freeze (freeze),
            .wr_en  (issue && id_wb_en && (id_dest == ADDR_W'(r))),
            .wr_lat (wr_lat),
            .entry  (entries[r])
         );
      end
   end

   // Returns {stall, sel}. An entry at pos==DEPTH is being written this cycle and reads through.
   function automatic logic [MAX_POS_W:0] resolve(input sb_entry_t e, input logic used,
                                                  input logic fwd);
      logic                 pending;
      logic                 stall;
      logic [MAX_POS_W-1:0] sel;
      pending = e.valid && (e.pos < MAX_POS_W'(DEPTH));
      stall   = 1'b0;
      sel     = SEL_REGFILE;
      if (used && pending) begin
         if (fwd) begin
            stall = (e.pos < e.lat);
            sel   = e.pos + MAX_POS_W'(1);
         end else begin
            stall = 1'b1;
         end
      end
      return {stall, sel};
   endfunction

   always_comb begin
      {stall1, sel1} = resolve(entries[id_src1], id_src1_used, forward_EN);
      {stall2, sel2} = resolve(entries[id_src2], id_src2_used, forward_EN);
   end

   assign hazard_detected = id_valid && !flush && (stall1 || stall2);
   assign issue           = id_valid && !hazard_detected && !freeze && !flush;

   always_comb begin
      sel1_d = sel1_q;
      sel2_d = sel2_q;
      if (issue) begin
         sel1_d = sel1[POS_W-1:0];
         sel2_d = sel2[POS_W-1:0];
      end else if (!freeze) begin
         sel1_d = '0;
         sel2_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel1_q <= '0;
         sel2_q <= '0;
      end else begin
         sel1_q <= sel1_d;
         sel2_q <= sel2_d;
      end
   end

   assign ex_src1_sel = sel1_q;
   assign ex_src2_sel = sel2_q;

   always_comb begin
      any_valid = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         any_valid = any_valid | entries[i].valid;
      end
   end

   assign sb_empty = !any_valid;

endmodule
`default_nettype wire

// File: tb/tb_scoreboard_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_scoreboard_hazard_unit : directed + random checks vs time model  |
// | Revision                  : 1.0                                    |
// +--------------------------------------------------------------------+
module tb_scoreboard_hazard_unit;

   localparam int NREGS  = 16;
   localparam int DEPTH  = 3;
   localparam int ADDR_W = 4;
   localparam int POS_W  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              forward_EN, freeze, flush;
   logic              id_valid, id_src1_used, id_src2_used, id_wb_en;
   logic [ADDR_W-1:0] id_src1, id_src2, id_dest;
   logic [POS_W-1:0]  id_lat;
   logic              hazard_detected, issue, sb_empty;
   logic [POS_W-1:0]  ex_src1_sel, ex_src2_sel;

   always #5 clk = ~clk;

   scoreboard_hazard_unit #(.NREGS(NREGS), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
      .clk             (clk),
      .rst             (rst),
      .forward_EN      (forward_EN),
      .freeze          (freeze),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_src1         (id_src1),
      .id_src2         (id_src2),
      .id_src1_used    (id_src1_used),
      .id_src2_used    (id_src2_used),
      .id_dest         (id_dest),
      .id_wb_en        (id_wb_en),
      .id_lat          (id_lat),
      .hazard_detected (hazard_detected),
      .issue           (issue),
      .ex_src1_sel     (ex_src1_sel),
      .ex_src2_sel     (ex_src2_sel),
      .sb_empty        (sb_empty)
   );

   // Reference: each register remembers the active-cycle timestamp of its last writer.
   // age = active cycles since issue; result usable at age+1 >= lat, regfile written at age DEPTH-1.
   bit m_set [NREGS];
   int m_t   [NREGS];
   int m_lat [NREGS];
   int T;
   int exp_sel1, exp_sel2;
   int n_checks, n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input int expv);
      n_checks++;
      assert (obs === 32'(expv)) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic m_reset();
      for (int r = 0; r < NREGS; r++) m_set[r] = 1'b0;
      T = 0;
      exp_sel1 = 0;
      exp_sel2 = 0;
   endtask

   function automatic bit m_pending(input int r);
      return m_set[r] && ((T - m_t[r]) < DEPTH - 1);
   endfunction

   function automatic bit m_empty();
      for (int r = 0; r < NREGS; r++)
         if (m_set[r] && ((T - m_t[r]) < DEPTH)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic m_eval(input int src, input bit used, output bit stall, output int sel);
      int age;
      stall = 1'b0;
      sel   = 0;
      if (used && src != 0 && m_pending(src)) begin
         age = T - m_t[src];
         if (forward_EN) begin
            stall = (age + 1) < m_lat[src];
            sel   = age + 2;
         end else begin
            stall = 1'b1;
         end
      end
   endtask

   task automatic set_instr(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                            input int d, input bit wb, input int lat);
      id_valid     = v;
      id_src1      = ADDR_W'(s1);
      id_src1_used = u1;
      id_src2      = ADDR_W'(s2);
      id_src2_used = u2;
      id_dest      = ADDR_W'(d);
      id_wb_en     = wb;
      id_lat       = POS_W'(lat);
   endtask

   task automatic idle();
      set_instr(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
   endtask

   // Called at posedge+1 with inputs applied; checks comb outputs, crosses one edge, checks state.
   task automatic step(input string tag, input int want_hz = -1,
                       input int want_s1 = -1, input int want_s2 = -1);
      bit s1, s2, hz, iss;
      int sel1, sel2, lat_eff;
      #1;
      m_eval(id_src1, id_src1_used, s1, sel1);
      m_eval(id_src2, id_src2_used, s2, sel2);
      hz  = id_valid && !flush && (s1 || s2);
      iss = id_valid && !hz && !freeze && !flush;
      chk({tag, " hazard"}, hazard_detected, hz);
      chk({tag, " issue"}, issue, iss);
      if (want_hz >= 0) chk({tag, " hazard_const"}, hazard_detected, want_hz);
      @(posedge clk);
      #1;
      if (iss) begin
         exp_sel1 = sel1;
         exp_sel2 = sel2;
      end else if (!freeze) begin
         exp_sel1 = 0;
         exp_sel2 = 0;
      end
      if (!freeze) begin
         T++;
         if (iss && id_wb_en && id_dest != 0) begin
            lat_eff = (id_lat == 0) ? 1 : ((id_lat > DEPTH - 1) ? DEPTH - 1 : int'(id_lat));
            m_set[id_dest] = 1'b1;
            m_t[id_dest]   = T;
            m_lat[id_dest] = lat_eff;
         end
      end
      chk({tag, " sel1"}, ex_src1_sel, exp_sel1);
      chk({tag, " sel2"}, ex_src2_sel, exp_sel2);
      chk({tag, " sb_empty"}, sb_empty, m_empty());
      if (want_s1 >= 0) chk({tag, " sel1_const"}, ex_src1_sel, want_s1);
      if (want_s2 >= 0) chk({tag, " sel2_const"}, ex_src2_sel, want_s2);
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < DEPTH + 1; i++) step("drain");
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      m_reset();
      rst = 1'b1;
      forward_EN = 1'b1;
      freeze = 1'b0;
      flush = 1'b0;
      idle();
      @(posedge clk);
      #1;
      chk("reset sel1", ex_src1_sel, 0);
      chk("reset sel2", ex_src2_sel, 0);
      chk("reset sb_empty", sb_empty, 1);
      chk("reset hazard", hazard_detected, 0);
      chk("reset issue", issue, 0);
      rst = 1'b0;

      // ALU -> back-to-back use
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1);
      step("alu prod");
      set_instr(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1);
      step("alu use", 0, 2, 0);
      drain();

      // Load -> use: one stall, then sel 3
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 2);
      step("ld prod");
      set_instr(1'b1, 0, 1'b0, 2, 1'b1, 6, 1'b1, 1);
      step("ld use stall", 1);
      step("ld use go", 0, 0, 3);
      drain();

      // Load -> distance 3 use: regfile
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 2);
      step("ld3 prod");
      idle();
      step("ld3 gap");
      step("ld3 gap");
      set_instr(1'b1, 0, 1'b0, 2, 1'b1, 6, 1'b1, 1);
      step("ld3 use", 0, 0, 0);
      drain();

      // Forwarding disabled: two stalls then regfile
      forward_EN = 1'b0;
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1);
      step("nofwd prod");
      set_instr(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1);
      step("nofwd stall a", 1);
      step("nofwd stall b", 1);
      step("nofwd go", 0, 0, 0);
      drain();
      forward_EN = 1'b1;

      // Freeze mid-flight holds position
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 2);
      step("frz prod");
      set_instr(1'b1, 4, 1'b1, 0, 1'b0, 7, 1'b1, 1);
      freeze = 1'b1;
      for (int i = 0; i < 4; i++) step("frz hold", 1, 0, 0);
      freeze = 1'b0;
      step("frz stall", 1);
      step("frz go", 0, 3, 0);
      drain();

      // WAW: younger ALU writer wins
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 2);
      step("waw load");
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1);
      step("waw alu");
      set_instr(1'b1, 3, 1'b1, 0, 1'b0, 8, 1'b1, 1);
      step("waw use", 0, 2, 0);
      drain();

      // r0 is never tracked
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 2);
      step("r0 prod");
      set_instr(1'b1, 0, 1'b1, 0, 1'b1, 9, 1'b1, 1);
      step("r0 use", 0, 0, 0);
      drain();

      // Flush masks a hazard
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 2);
      step("fl prod");
      set_instr(1'b1, 6, 1'b1, 6, 1'b1, 10, 1'b1, 1);
      flush = 1'b1;
      step("fl use", 0, 0, 0);
      flush = 1'b0;
      drain();

      // Asynchronous reset mid-flight
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 2);
      step("rst prod");
      set_instr(1'b1, 0, 1'b0, 0, 1'b0, 8, 1'b1, 1);
      step("rst prod2");
      set_instr(1'b1, 7, 1'b1, 8, 1'b1, 11, 1'b1, 1);
      #1;
      chk("pre-rst sb_empty", sb_empty, 0);
      rst = 1'b1;
      #1;
      m_reset();
      chk("rst sb_empty", sb_empty, 1);
      chk("rst sel1", ex_src1_sel, 0);
      chk("rst sel2", ex_src2_sel, 0);
      chk("rst hazard", hazard_detected, 0);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      step("post-rst use", 0, 0, 0);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 29) == 0) forward_EN = ~forward_EN;
         freeze = ($urandom_range(0, 7) == 0);
         flush  = ($urandom_range(0, 11) == 0);
         set_instr($urandom_range(0, 4) != 0,
                   $urandom_range(0, 5), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 5), $urandom_range(0, 2) != 0,
                   $urandom_range(0, 5), $urandom_range(0, 4) != 0,
                   $urandom_range(0, 3));
         step("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
